// File: rtl/hs_memory_if.sv
// Request/response bus of hs_memory: one request channel, one response channel,
// both valid/ready handshaked.
interface hs_memory_if #(
  parameter int AW = 11
);
  logic          i_req_valid;
  logic          o_req_ready;
  logic [AW-1:0] i_addr;
  logic          i_wren;
  logic [3:0]    i_bmask;
  logic [31:0]   i_wdata;
  logic          o_rsp_valid;
  logic          i_rsp_ready;
  logic [31:0]   o_rdata;
  logic          o_rsp_err;

  modport master (
    output i_req_valid, i_addr, i_wren, i_bmask, i_wdata, i_rsp_ready,
    input  o_req_ready, o_rsp_valid, o_rdata, o_rsp_err
  );

  modport slave (
    input  i_req_valid, i_addr, i_wren, i_bmask, i_wdata, i_rsp_ready,
    output o_req_ready, o_rsp_valid, o_rdata, o_rsp_err
  );
endinterface

// File: rtl/hs_memory.sv
// hs_memory: byte-addressed handshake memory with byte-lane masks; misaligned
// accesses crossing a word run as two beats when HS_MEMORY_MISALIGN_EN is defined.
module hs_memory #(
  parameter int N = 2048
) (
  input  logic        i_clk,
  input  logic        i_reset,
  hs_memory_if.slave  bus
);
  localparam int AW    = $clog2(N);
  localparam int WW    = AW - 2;
  localparam int DEPTH = N / 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT0 = 2'd1,
`ifdef HS_MEMORY_MISALIGN_EN
    ST_BEAT1 = 2'd3,
`endif
    ST_RESP  = 2'd2
  } state_t;

  state_t        state_q;
  logic [AW-1:0] addr_q;
  logic          wren_q;
  logic [3:0]    bmask_q;
  logic [31:0]   wdata_q;
  logic          req_ready_q;
  logic          rsp_valid_q;
  logic [31:0]   rdata_q;
  logic          rsp_err_q;
  logic [31:0]   mem_q [DEPTH];

  logic [3:0]      touch_s;
  logic [3:0]      hi_s;
  logic [3:0]      inrng_s;
  logic [3:0][1:0] sel_s;
  logic            align_ok_s;
  logic            err_s;
  logic [WW-1:0]   word0_s;
  logic [31:0]     rd0_word_s;
  logic [31:0]     rd_lanes0_s;
  logic            wr_en_s;
  logic [WW-1:0]   wr_idx_s;
  logic [3:0]      wr_be_s;
  logic [31:0]     wr_data_s;
`ifdef HS_MEMORY_MISALIGN_EN
  logic            split_s;
  logic [WW:0]     word1_s;
  logic [31:0]     rd1_word_s;
  logic [31:0]     rd_lanes1_s;
`endif

  assign bus.o_req_ready = req_ready_q;
  assign bus.o_rsp_valid = rsp_valid_q;
  assign bus.o_rdata     = rdata_q;
  assign bus.o_rsp_err   = rsp_err_q;

  // Lane geometry of the captured access: hi_s marks lanes landing in the next word
  always_comb begin
    logic [AW:0] badr_v;
    logic [2:0]  pos_v;
    touch_s = wren_q ? bmask_q : 4'b1111;
    hi_s    = 4'b0000;
    inrng_s = 4'b0000;
    sel_s   = 8'h00;
    for (int k = 0; k < 4; k++) begin
      pos_v      = {1'b0, addr_q[1:0]} + 3'(k);
      badr_v     = {1'b0, addr_q} + (AW+1)'(k);
      hi_s[k]    = pos_v[2];
      sel_s[k]   = pos_v[1:0];
      inrng_s[k] = (badr_v < (AW+1)'(N));
    end
`ifdef HS_MEMORY_MISALIGN_EN
    split_s    = |(touch_s & hi_s);
    align_ok_s = 1'b1;
`else
    align_ok_s = (addr_q[1:0] == 2'b00);
`endif
    err_s = (|(touch_s & ~inrng_s)) | ~align_ok_s;
  end

  // Read lanes; out-of-range lanes are masked, so an invalid word index is harmless
  always_comb begin
    word0_s     = addr_q[AW-1:2];
    rd0_word_s  = mem_q[word0_s];
    rd_lanes0_s = 32'h0000_0000;
    for (int k = 0; k < 4; k++) begin
      rd_lanes0_s[8*k +: 8] = (!wren_q && align_ok_s && inrng_s[k] && !hi_s[k]) ?
                              rd0_word_s[{sel_s[k], 3'b000} +: 8] : 8'h00;
    end
`ifdef HS_MEMORY_MISALIGN_EN
    word1_s     = {1'b0, word0_s} + (WW+1)'(1);
    rd1_word_s  = mem_q[word1_s[WW-1:0]];
    rd_lanes1_s = 32'h0000_0000;
    for (int k = 0; k < 4; k++) begin
      rd_lanes1_s[8*k +: 8] = (!wren_q && inrng_s[k] && hi_s[k]) ?
                              rd1_word_s[{sel_s[k], 3'b000} +: 8] : 8'h00;
    end
`endif
  end

  // Write port: byte b of the addressed word takes lane (b - addr[1:0]) mod 4
  always_comb begin
    logic [1:0] k_v;
    logic       b1_v;
    case (state_q)
      ST_BEAT0: begin
        wr_en_s  = wren_q & ~err_s;
        wr_idx_s = word0_s;
        b1_v     = 1'b0;
      end
`ifdef HS_MEMORY_MISALIGN_EN
      ST_BEAT1: begin
        wr_en_s  = wren_q & ~err_s;
        wr_idx_s = word1_s[WW-1:0];
        b1_v     = 1'b1;
      end
`endif
      default: begin
        wr_en_s  = 1'b0;
        wr_idx_s = word0_s;
        b1_v     = 1'b0;
      end
    endcase
    wr_be_s   = 4'b0000;
    wr_data_s = 32'h0000_0000;
    for (int b = 0; b < 4; b++) begin
      k_v                 = 2'(b) - addr_q[1:0];
      wr_be_s[b]          = touch_s[k_v] & (hi_s[k_v] == b1_v);
      wr_data_s[8*b +: 8] = wdata_q[{k_v, 3'b000} +: 8];
    end
  end

  // Storage array, cleared by reset
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int w = 0; w < DEPTH; w++) begin
        mem_q[w] <= 32'h0000_0000;
      end
    end else if (wr_en_s) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be_s[b]) begin
          mem_q[wr_idx_s][8*b +: 8] <= wr_data_s[8*b +: 8];
        end
      end
    end
  end

  // Access sequencer with registered handshake and response outputs
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= {AW{1'b0}};
      wren_q      <= 1'b0;
      bmask_q     <= 4'b0000;
      wdata_q     <= 32'h0000_0000;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rdata_q     <= 32'h0000_0000;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.i_req_valid) begin
            addr_q      <= bus.i_addr;
            wren_q      <= bus.i_wren;
            bmask_q     <= bus.i_bmask;
            wdata_q     <= bus.i_wdata;
            rdata_q     <= 32'h0000_0000;
            rsp_err_q   <= 1'b0;
            req_ready_q <= 1'b0;
            state_q     <= ST_BEAT0;
          end
        end
        ST_BEAT0: begin
          rdata_q   <= rd_lanes0_s;
          rsp_err_q <= err_s;
`ifdef HS_MEMORY_MISALIGN_EN
          if (split_s) begin
            state_q <= ST_BEAT1;
          end else begin
            state_q     <= ST_RESP;
            rsp_valid_q <= 1'b1;
          end
`else
          state_q     <= ST_RESP;
          rsp_valid_q <= 1'b1;
`endif
        end
`ifdef HS_MEMORY_MISALIGN_EN
        ST_BEAT1: begin
          rdata_q     <= rdata_q | rd_lanes1_s;
          state_q     <= ST_RESP;
          rsp_valid_q <= 1'b1;
        end
`endif
        ST_RESP: begin
          if (bus.i_rsp_ready) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
            rdata_q     <= 32'h0000_0000;
            rsp_err_q   <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end
endmodule
